// File: rtl/pipe_pkg.sv
// Shared pipeline-control definitions: sequencer state encoding, register
// constants and the load-use hazard detector.
package pipe_pkg;

  localparam int unsigned REG_W        = 5;
  localparam int unsigned ID_EX_CTRL_W = 9;
  localparam int unsigned INIT_CNT_W   = 4;

  localparam logic [REG_W-1:0] REG_ZERO = 5'd0;

  typedef enum logic [1:0] {
    INIT    = 2'd0,
    RUN     = 2'd1,
    MEMWAIT = 2'd2
  } state_e;

  // A load writing r0 never creates a real dependency.
  function automatic logic load_use_hit(
    input logic             memread,
    input logic [REG_W-1:0] ex_rt,
    input logic [REG_W-1:0] id_rs,
    input logic [REG_W-1:0] id_rt
  );
    return memread && (ex_rt != REG_ZERO) && ((ex_rt == id_rs) || (ex_rt == id_rt));
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; holds at all-ones.
module sat_counter #(
  parameter int unsigned W = 16
) (
  input  logic         clk,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] count
);

  always_ff @(posedge clk) begin
    if (clr) begin
      count <= '0;
    end else if (inc && (count != '1)) begin
      count <= count + W'(1);
    end
  end

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline sequencing controller: stall/flush/freeze decisions for PC, IF_ID,
// ID_EX and EX_MEM plus saturating stall/flush statistics.
module hazard_ctrl
  import pipe_pkg::*;
#(
  parameter int unsigned INIT_CYCLES = 4,
  parameter int unsigned CNT_W       = 16
) (
  input  logic             clk,
  input  logic             startin,
  input  logic             id_ex_memread,
  input  logic [REG_W-1:0] id_ex_rt,
  input  logic [REG_W-1:0] if_id_rs,
  input  logic [REG_W-1:0] if_id_rt,
  input  logic             id_jump,
  input  logic             ex_branch_taken,
  input  logic             mem_busy,
  output logic             pc_write,
  output logic             if_id_write,
  output logic             if_id_flush,
  output logic             id_ex_flush,
  output logic             ex_mem_write,
  output logic [CNT_W-1:0] stall_count,
  output logic [CNT_W-1:0] flush_count
);

  localparam logic [INIT_CNT_W-1:0] INIT_LAST = INIT_CNT_W'(INIT_CYCLES - 1);

  state_e                  state_q, state_d;
  logic [INIT_CNT_W-1:0]   init_cnt_q, init_cnt_d;
  logic                    pend_br_q, pend_br_d;
  logic                    stall_inc, flush_inc;
  logic                    load_use;

  assign load_use = load_use_hit(id_ex_memread, id_ex_rt, if_id_rs, if_id_rt);

  // State register; reset discards any deferred branch flush.
  always_ff @(posedge clk) begin
    if (startin) begin
      state_q    <= INIT;
      init_cnt_q <= '0;
      pend_br_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      init_cnt_q <= init_cnt_d;
      pend_br_q  <= pend_br_d;
    end
  end

  // Next-state and control decisions, highest priority first.
  always_comb begin
    state_d      = state_q;
    init_cnt_d   = init_cnt_q;
    pend_br_d    = pend_br_q;
    stall_inc    = 1'b0;
    flush_inc    = 1'b0;
    pc_write     = 1'b0;
    if_id_write  = 1'b0;
    ex_mem_write = 1'b0;
    if_id_flush  = 1'b1;
    id_ex_flush  = 1'b1;

    if (!startin) begin
      case (state_q)
        INIT: begin
          init_cnt_d = init_cnt_q + INIT_CNT_W'(1);
          if (init_cnt_q == INIT_LAST) state_d = RUN;
        end
        RUN, MEMWAIT: begin
          if (mem_busy) begin
            if_id_flush = 1'b0;
            id_ex_flush = 1'b0;
            stall_inc   = 1'b1;
            state_d     = MEMWAIT;
            if (ex_branch_taken) pend_br_d = 1'b1;
          end else if (ex_branch_taken || pend_br_q) begin
            pc_write     = 1'b1;
            if_id_write  = 1'b1;
            ex_mem_write = 1'b1;
            pend_br_d    = 1'b0;
            flush_inc    = 1'b1;
            state_d      = RUN;
          end else if (load_use) begin
            ex_mem_write = 1'b1;
            if_id_flush  = 1'b0;
            stall_inc    = 1'b1;
            state_d      = RUN;
          end else if (id_jump) begin
            pc_write     = 1'b1;
            if_id_write  = 1'b1;
            ex_mem_write = 1'b1;
            id_ex_flush  = 1'b0;
            flush_inc    = 1'b1;
            state_d      = RUN;
          end else begin
            pc_write     = 1'b1;
            if_id_write  = 1'b1;
            ex_mem_write = 1'b1;
            if_id_flush  = 1'b0;
            id_ex_flush  = 1'b0;
            state_d      = RUN;
          end
        end
        default: state_d = INIT;
      endcase
    end
  end

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .clr   (startin),
    .inc   (stall_inc),
    .count (stall_count)
  );

  sat_counter #(.W(CNT_W)) u_flush_cnt (
    .clk   (clk),
    .clr   (startin),
    .inc   (flush_inc),
    .count (flush_count)
  );

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl: a 16-bit-counter instance and a 2-bit-counter
// instance share all inputs so saturation is observed alongside normal counts.
module tb_hazard_ctrl;

  logic       clk = 1'b0;
  logic       startin;
  logic       id_ex_memread;
  logic [4:0] id_ex_rt;
  logic [4:0] if_id_rs;
  logic [4:0] if_id_rt;
  logic       id_jump;
  logic       ex_branch_taken;
  logic       mem_busy;

  logic        pc_write, if_id_write, if_id_flush, id_ex_flush, ex_mem_write;
  logic [15:0] stall_count, flush_count;
  logic        s_pc_write, s_if_id_write, s_if_id_flush, s_id_ex_flush, s_ex_mem_write;
  logic [1:0]  s_stall_count, s_flush_count;

  int checks = 0;
  int fails  = 0;

  always #5 clk = ~clk;

  hazard_ctrl #(.INIT_CYCLES(4), .CNT_W(16)) dut (
    .clk             (clk),
    .startin         (startin),
    .id_ex_memread   (id_ex_memread),
    .id_ex_rt        (id_ex_rt),
    .if_id_rs        (if_id_rs),
    .if_id_rt        (if_id_rt),
    .id_jump         (id_jump),
    .ex_branch_taken (ex_branch_taken),
    .mem_busy        (mem_busy),
    .pc_write        (pc_write),
    .if_id_write     (if_id_write),
    .if_id_flush     (if_id_flush),
    .id_ex_flush     (id_ex_flush),
    .ex_mem_write    (ex_mem_write),
    .stall_count     (stall_count),
    .flush_count     (flush_count)
  );

  hazard_ctrl #(.INIT_CYCLES(4), .CNT_W(2)) dut_sat (
    .clk             (clk),
    .startin         (startin),
    .id_ex_memread   (id_ex_memread),
    .id_ex_rt        (id_ex_rt),
    .if_id_rs        (if_id_rs),
    .if_id_rt        (if_id_rt),
    .id_jump         (id_jump),
    .ex_branch_taken (ex_branch_taken),
    .mem_busy        (mem_busy),
    .pc_write        (s_pc_write),
    .if_id_write     (s_if_id_write),
    .if_id_flush     (s_if_id_flush),
    .id_ex_flush     (s_id_ex_flush),
    .ex_mem_write    (s_ex_mem_write),
    .stall_count     (s_stall_count),
    .flush_count     (s_flush_count)
  );

  // Packed {pc_write, if_id_write, if_id_flush, id_ex_flush, ex_mem_write}
  function automatic logic [4:0] ctl();
    return {pc_write, if_id_write, if_id_flush, id_ex_flush, ex_mem_write};
  endfunction

  // Advance to the next falling edge and apply a fresh input vector.
  task automatic drive(input logic rst, input logic mr, input logic [4:0] ert,
                       input logic [4:0] rs, input logic [4:0] rt, input logic jmp,
                       input logic br, input logic busy);
    @(negedge clk);
    startin = rst; id_ex_memread = mr; id_ex_rt = ert; if_id_rs = rs; if_id_rt = rt;
    id_jump = jmp; ex_branch_taken = br; mem_busy = busy;
    #1;
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_reset();
    drive(1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
    drive(1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
    checks++;
    if (ctl() !== 5'b00110) begin
      fails++; $display("FAIL reset_ctl: got %b expected 00110", ctl());
    end
    checks++;
    if (stall_count !== 16'd0 || flush_count !== 16'd0) begin
      fails++; $display("FAIL reset_cnt: got stall=%0d flush=%0d expected 0/0", stall_count, flush_count);
    end
    // Hazards presented during the fill window must be ignored.
    for (int i = 0; i < 4; i++) begin
      drive(1'b0, 1'b1, 5'd3, 5'd3, 5'd0, 1'b1, 1'b1, 1'b0);
      checks++;
      if (ctl() !== 5'b00110) begin
        fails++; $display("FAIL init_ctl[%0d]: got %b expected 00110", i, ctl());
      end
    end
    idle();
    checks++;
    if (ctl() !== 5'b11001) begin
      fails++; $display("FAIL run_ctl: got %b expected 11001", ctl());
    end
    checks++;
    if (stall_count !== 16'd0 || flush_count !== 16'd0) begin
      fails++; $display("FAIL init_cnt: got stall=%0d flush=%0d expected 0/0", stall_count, flush_count);
    end
  endtask

  task automatic test_load_use();
    drive(1'b0, 1'b1, 5'd5, 5'd5, 5'd0, 1'b0, 1'b0, 1'b0);
    checks++;
    if (ctl() !== 5'b00011) begin
      fails++; $display("FAIL lu_rs_ctl: got %b expected 00011", ctl());
    end
    idle();
    checks++;
    if (ctl() !== 5'b11001 || stall_count !== 16'd1) begin
      fails++; $display("FAIL lu_rs_after: got ctl=%b stall=%0d expected 11001/1", ctl(), stall_count);
    end
    drive(1'b0, 1'b1, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
    checks++;
    if (ctl() !== 5'b11001) begin
      fails++; $display("FAIL lu_r0_ctl: got %b expected 11001", ctl());
    end
    drive(1'b0, 1'b1, 5'd7, 5'd1, 5'd7, 1'b0, 1'b0, 1'b0);
    checks++;
    if (ctl() !== 5'b00011 || stall_count !== 16'd1) begin
      fails++; $display("FAIL lu_rt_ctl: got ctl=%b stall=%0d expected 00011/1", ctl(), stall_count);
    end
    idle();
    checks++;
    if (stall_count !== 16'd2 || s_stall_count !== 2'd2) begin
      fails++; $display("FAIL lu_cnt: got stall=%0d sat=%0d expected 2/2", stall_count, s_stall_count);
    end
  endtask

  task automatic test_branch_over_load_use();
    drive(1'b0, 1'b1, 5'd5, 5'd5, 5'd0, 1'b0, 1'b1, 1'b0);
    checks++;
    if (ctl() !== 5'b11111) begin
      fails++; $display("FAIL br_lu_ctl: got %b expected 11111", ctl());
    end
    idle();
    checks++;
    if (flush_count !== 16'd1 || stall_count !== 16'd2) begin
      fails++; $display("FAIL br_lu_cnt: got flush=%0d stall=%0d expected 1/2", flush_count, stall_count);
    end
  endtask

  task automatic test_deferred_branch();
    drive(1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b1);
    checks++;
    if (ctl() !== 5'b00000) begin
      fails++; $display("FAIL defer_freeze0: got %b expected 00000", ctl());
    end
    for (int i = 1; i < 3; i++) begin
      drive(1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1);
      checks++;
      if (ctl() !== 5'b00000) begin
        fails++; $display("FAIL defer_freeze%0d: got %b expected 00000", i, ctl());
      end
    end
    idle();
    checks++;
    if (ctl() !== 5'b11111 || stall_count !== 16'd5 || flush_count !== 16'd1) begin
      fails++; $display("FAIL defer_flush: got ctl=%b stall=%0d flush=%0d expected 11111/5/1",
                        ctl(), stall_count, flush_count);
    end
    idle();
    checks++;
    if (ctl() !== 5'b11001 || flush_count !== 16'd2) begin
      fails++; $display("FAIL defer_after: got ctl=%b flush=%0d expected 11001/2", ctl(), flush_count);
    end
    checks++;
    if (s_stall_count !== 2'd3 || s_flush_count !== 2'd2) begin
      fails++; $display("FAIL sat_stall: got stall=%0d flush=%0d expected 3/2", s_stall_count, s_flush_count);
    end
  endtask

  task automatic test_jump();
    drive(1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0);
    checks++;
    if (ctl() !== 5'b11101) begin
      fails++; $display("FAIL jump_ctl: got %b expected 11101", ctl());
    end
    idle();
    checks++;
    if (flush_count !== 16'd3 || s_flush_count !== 2'd3) begin
      fails++; $display("FAIL jump_cnt: got flush=%0d sat=%0d expected 3/3", flush_count, s_flush_count);
    end
  endtask

  task automatic test_back_to_back();
    drive(1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0);
    drive(1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b1, 1'b1, 1'b0);
    checks++;
    if (ctl() !== 5'b11111 || flush_count !== 16'd4) begin
      fails++; $display("FAIL b2b_ctl: got ctl=%b flush=%0d expected 11111/4", ctl(), flush_count);
    end
    idle();
    checks++;
    if (flush_count !== 16'd5 || s_flush_count !== 2'd3) begin
      fails++; $display("FAIL b2b_cnt: got flush=%0d sat=%0d expected 5/3", flush_count, s_flush_count);
    end
  endtask

  task automatic test_reset_in_memwait();
    drive(1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b1);
    drive(1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1);
    checks++;
    if (ctl() !== 5'b00110 || stall_count !== 16'd6) begin
      fails++; $display("FAIL rst_mw_ctl: got ctl=%b stall=%0d expected 00110/6", ctl(), stall_count);
    end
    for (int i = 0; i < 4; i++) begin
      idle();
      checks++;
      if (ctl() !== 5'b00110) begin
        fails++; $display("FAIL rst_mw_init[%0d]: got %b expected 00110", i, ctl());
      end
    end
    idle();
    checks++;
    if (ctl() !== 5'b11001 || stall_count !== 16'd0 || flush_count !== 16'd0) begin
      fails++; $display("FAIL rst_mw_run: got ctl=%b stall=%0d flush=%0d expected 11001/0/0",
                        ctl(), stall_count, flush_count);
    end
    idle();
    checks++;
    if (flush_count !== 16'd0) begin
      fails++; $display("FAIL rst_mw_noflush: got flush=%0d expected 0", flush_count);
    end
  endtask

  initial begin
    startin = 1'b1; id_ex_memread = 1'b0; id_ex_rt = 5'd0; if_id_rs = 5'd0;
    if_id_rt = 5'd0; id_jump = 1'b0; ex_branch_taken = 1'b0; mem_busy = 1'b0;
    test_reset();
    test_load_use();
    test_branch_over_load_use();
    test_deferred_branch();
    test_jump();
    test_back_to_back();
    test_reset_in_memwait();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
